// File: rtl/conv_ctrl_axi_lite_v2.sv
// conv_ctrl_axi_lite_v2: AXI4-Lite control/status slave for the 2D convolution
// pipeline. It holds the frame FSM, the frame counter and the per-tap coefficient
// shadows. The shadows are copied to filter_weights on each start pulse.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_axi_control_*      AXI4-Lite slave (AW/W/B/AR/R)
//   tlast                last pixel of the current frame, from the datapath
//   start                one-cycle frame-start pulse
//   run                  high while a frame is in progress
//   filter_weights       active coefficients; tap k at [k*COEF_WIDTH +: COEF_WIDTH]
//   irq                  done_sticky & irq_en (only with CONV_CTRL_IRQ_EN)
// Optional feature macro: CONV_CTRL_IRQ_EN adds the irq port and CTRL bit3 irq_en.
module conv_ctrl_axi_lite_v2 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned COEF_WIDTH  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH-1:0]             s_axi_control_awaddr,
  input  logic                              s_axi_control_awvalid,
  output logic                              s_axi_control_awready,
  input  logic [DATA_WIDTH-1:0]             s_axi_control_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axi_control_wstrb,
  input  logic                              s_axi_control_wvalid,
  output logic                              s_axi_control_wready,
  output logic [1:0]                        s_axi_control_bresp,
  output logic                              s_axi_control_bvalid,
  input  logic                              s_axi_control_bready,
  input  logic [ADDR_WIDTH-1:0]             s_axi_control_araddr,
  input  logic                              s_axi_control_arvalid,
  output logic                              s_axi_control_arready,
  output logic [DATA_WIDTH-1:0]             s_axi_control_rdata,
  output logic [1:0]                        s_axi_control_rresp,
  output logic                              s_axi_control_rvalid,
  input  logic                              s_axi_control_rready,
  input  logic                              tlast,
  output logic                              start,
  output logic                              run,
`ifdef CONV_CTRL_IRQ_EN
  output logic                              irq,
`endif
  output logic [KERNEL_TAPS*COEF_WIDTH-1:0] filter_weights
);
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned FW_W   = KERNEL_TAPS * COEF_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  function automatic logic is_coef(input logic [IDX_W-1:0] idx);
    return (32'(idx) >= 32'd4) && (32'(idx) < 32'(4 + KERNEL_TAPS));
  endfunction

  state_t                  state, state_n;
  logic                    start_n;
  logic                    aw_held, w_held;
  logic [IDX_W-1:0]        aw_idx;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    ctrl_en, ctrl_cont;
  logic                    done_sticky;
  logic [DATA_WIDTH-1:0]   frame_cnt;
  logic [COEF_WIDTH-1:0]   coef [KERNEL_TAPS];
  logic [FW_W-1:0]         coef_flat_c;
  logic [DATA_WIDTH-1:0]   rd_data_c;
  logic                    rd_err_c;
  logic [IDX_W-1:0]        ar_idx_c;
`ifdef CONV_CTRL_IRQ_EN
  logic                    ctrl_irq_en;
`endif

  // Handshake and decoded write events
  logic aw_fire_c, w_fire_c, ar_fire_c, do_write_c;
  logic wr_ctrl_c, abort_c, done_clr_c, fcnt_clr_c, wr_err_c, frame_inc_c;
  logic aw_held_n_c, w_held_n_c, bvalid_n_c, rvalid_n_c;

  assign aw_fire_c   = s_axi_control_awvalid & s_axi_control_awready;
  assign w_fire_c    = s_axi_control_wvalid & s_axi_control_wready;
  assign ar_fire_c   = s_axi_control_arvalid & s_axi_control_arready;
  assign do_write_c  = aw_held & w_held;
  assign wr_ctrl_c   = do_write_c && (aw_idx == IDX_W'(0)) && wstrb_q[0];
  assign abort_c     = wr_ctrl_c & wdata_q[2];
  assign done_clr_c  = do_write_c && (aw_idx == IDX_W'(1)) && wstrb_q[1] && wdata_q[8];
  assign fcnt_clr_c  = do_write_c && (aw_idx == IDX_W'(2));
  assign wr_err_c    = !((aw_idx < IDX_W'(3)) || is_coef(aw_idx));
  assign frame_inc_c = (state == S_RUN) && tlast && !abort_c;
  assign ar_idx_c    = s_axi_control_araddr[ADDR_WIDTH-1:2];

  // Ready flags are registered from the next-cycle holding state
  assign aw_held_n_c = do_write_c ? 1'b0 : (aw_held | aw_fire_c);
  assign w_held_n_c  = do_write_c ? 1'b0 : (w_held | w_fire_c);
  assign bvalid_n_c  = do_write_c | (s_axi_control_bvalid & ~s_axi_control_bready);
  assign rvalid_n_c  = ar_fire_c | (s_axi_control_rvalid & ~s_axi_control_rready);

  // Frame FSM next state; an abort write beats a coincident tlast
  always_comb begin
    state_n = state;
    start_n = 1'b0;
    unique case (state)
      S_IDLE: if (ctrl_en) begin
        state_n = S_RUN;
        start_n = 1'b1;
      end
      S_RUN: begin
        if (abort_c) state_n = S_IDLE;
        else if (tlast) begin
          if (ctrl_cont) start_n = 1'b1;
          else           state_n = S_DONE;
        end
      end
      S_DONE: if (!ctrl_en) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      start          <= 1'b0;
      run            <= 1'b0;
      filter_weights <= '0;
    end else begin
      state <= state_n;
      start <= start_n;
      run   <= (state_n == S_RUN);
      if (start_n) filter_weights <= coef_flat_c;
    end
  end

  always_comb begin
    coef_flat_c = '0;
    for (int unsigned k = 0; k < KERNEL_TAPS; k++)
      coef_flat_c[k*COEF_WIDTH +: COEF_WIDTH] = coef[k];
  end

  // AW/W capture and B response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held               <= 1'b0;
      w_held                <= 1'b0;
      aw_idx                <= '0;
      wdata_q               <= '0;
      wstrb_q               <= '0;
      s_axi_control_awready <= 1'b0;
      s_axi_control_wready  <= 1'b0;
      s_axi_control_bvalid  <= 1'b0;
      s_axi_control_bresp   <= 2'b00;
    end else begin
      aw_held               <= aw_held_n_c;
      w_held                <= w_held_n_c;
      s_axi_control_bvalid  <= bvalid_n_c;
      s_axi_control_awready <= ~aw_held_n_c & ~bvalid_n_c;
      s_axi_control_wready  <= ~w_held_n_c & ~bvalid_n_c;
      if (aw_fire_c) aw_idx <= s_axi_control_awaddr[ADDR_WIDTH-1:2];
      if (w_fire_c) begin
        wdata_q <= s_axi_control_wdata;
        wstrb_q <= s_axi_control_wstrb;
      end
      if (do_write_c) s_axi_control_bresp <= wr_err_c ? 2'b10 : 2'b00;
    end
  end

  // Control, status, counter and coefficient shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_cont   <= 1'b0;
      done_sticky <= 1'b0;
      frame_cnt   <= '0;
      for (int unsigned k = 0; k < KERNEL_TAPS; k++) coef[k] <= '0;
    end else begin
      if (wr_ctrl_c) begin
        ctrl_en   <= wdata_q[0];
        ctrl_cont <= wdata_q[1];
      end
      done_sticky <= frame_inc_c | (done_sticky & ~done_clr_c);
      if (fcnt_clr_c)       frame_cnt <= DATA_WIDTH'(frame_inc_c);
      else if (frame_inc_c) frame_cnt <= frame_cnt + DATA_WIDTH'(1);
      for (int unsigned k = 0; k < KERNEL_TAPS; k++) begin
        if (do_write_c && (aw_idx == IDX_W'(4 + k))) begin
          for (int unsigned b = 0; b < COEF_WIDTH; b++)
            if (wstrb_q[b/8]) coef[k][b] <= wdata_q[b];
        end
      end
    end
  end

`ifdef CONV_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_irq_en <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl_c) ctrl_irq_en <= wdata_q[3];
      irq <= done_sticky & ctrl_irq_en;
    end
  end
`endif

  // Read mux
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    if (ar_idx_c == IDX_W'(0)) begin
      rd_data_c[0] = ctrl_en;
      rd_data_c[1] = ctrl_cont;
`ifdef CONV_CTRL_IRQ_EN
      rd_data_c[3] = ctrl_irq_en;
`endif
    end else if (ar_idx_c == IDX_W'(1)) begin
      rd_data_c[1:0] = state;
      rd_data_c[8]   = done_sticky;
    end else if (ar_idx_c == IDX_W'(2)) begin
      rd_data_c = frame_cnt;
    end else if (ar_idx_c == IDX_W'(3)) begin
      rd_data_c = '0;
    end else if (is_coef(ar_idx_c)) begin
      for (int unsigned k = 0; k < KERNEL_TAPS; k++)
        if (ar_idx_c == IDX_W'(4 + k)) rd_data_c[COEF_WIDTH-1:0] = coef[k];
    end else begin
      rd_err_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_control_rvalid  <= 1'b0;
      s_axi_control_arready <= 1'b0;
      s_axi_control_rdata   <= '0;
      s_axi_control_rresp   <= 2'b00;
    end else begin
      s_axi_control_rvalid  <= rvalid_n_c;
      s_axi_control_arready <= ~rvalid_n_c;
      if (ar_fire_c) begin
        s_axi_control_rdata <= rd_data_c;
        s_axi_control_rresp <= rd_err_c ? 2'b10 : 2'b00;
      end
    end
  end

  // Byte-offset address bits and unused data/strobe bits are intentionally ignored
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0],
                         wdata_q, wstrb_q};

endmodule

// File: tb/tb_conv_ctrl_axi_lite_v2.sv
// Scoreboard bench for conv_ctrl_axi_lite_v2: stimulus tasks push expected B/R
// responses into queues and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_conv_ctrl_axi_lite_v2;
  localparam int unsigned KT = 9;
  localparam int unsigned CW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        tlast = 1'b0;
  logic        start;
  logic        run;
  logic [KT*CW-1:0] filter_weights;
`ifdef CONV_CTRL_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  conv_ctrl_axi_lite_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .KERNEL_TAPS(KT), .COEF_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb), .s_axi_control_wvalid(wvalid),
    .s_axi_control_wready(wready), .s_axi_control_bresp(bresp), .s_axi_control_bvalid(bvalid),
    .s_axi_control_bready(bready), .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid),
    .s_axi_control_arready(arready), .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .tlast(tlast), .start(start), .run(run),
`ifdef CONV_CTRL_IRQ_EN
    .irq(irq),
`endif
    .filter_weights(filter_weights)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  bit run_armed = 1'b0;
  bit run_dropped = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor and start/run observers
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) check("unexpected_b", 64'(bvalid), 64'd0);
      else begin
        exp_t e;
        e = bq.pop_front();
        check({e.name, "_bresp"}, 64'(bresp), 64'(e.resp));
      end
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) check("unexpected_r", 64'(rvalid), 64'd0);
      else begin
        exp_t e;
        e = rq.pop_front();
        check({e.name, "_rdata"}, 64'(rdata), 64'(e.data));
        check({e.name, "_rresp"}, 64'(rresp), 64'(e.resp));
      end
    end
    if (rst_n && start) start_cnt++;
    if (run_armed && !run) run_dropped = 1'b1;
  end

  task automatic drain(input string name);
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      check({name, "_timeout"}, 64'(bq.size() + rq.size()), 64'd0);
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input string name, input int aw_delay);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit a, w;
    int c = 0;
    bq.push_back('{data: 32'd0, resp: resp, name: name});
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      if (c >= aw_delay && !aw_done) awvalid = 1'b1;
      a = awvalid && awready;
      w = wvalid && wready;
      @(posedge clk); #1;
      if (a) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w) begin wvalid = 1'b0; w_done = 1'b1; end
      c++;
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check({name, "_hs_timeout"}, 64'({aw_done, w_done}), 64'd3);
    drain(name);
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input string name);
    bit done = 1'b0;
    bit a;
    int c = 0;
    rq.push_back('{data: data, resp: resp, name: name});
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!done && c < 50) begin
      a = arvalid && arready;
      @(posedge clk); #1;
      if (a) begin arvalid = 1'b0; done = 1'b1; end
      c++;
      if (!done) @(negedge clk);
    end
    arvalid = 1'b0;
    if (!done) check({name, "_ar_timeout"}, 64'(done), 64'd1);
    drain(name);
  endtask

  // AW+W handshake in one cycle so the register update coincides with a tlast cycle
  task automatic write_with_tlast(input logic [5:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, input logic [1:0] resp, input string name);
    bq.push_back('{data: 32'd0, resp: resp, name: name});
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    check({name, "_ready"}, 64'(awready & wready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; tlast = 1'b1;
    @(posedge clk); #1;
    tlast = 1'b0;
    drain(name);
  endtask

  task automatic pulse_tlast();
    @(negedge clk); tlast = 1'b1;
    @(negedge clk); tlast = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_run(input logic val, input string name);
    int n = 0;
    while (run !== val && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 64'(run), 64'(val));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals [KT] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [KT*CW-1:0] exp_fw;
    logic [KT*CW-1:0] exp_fw2;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_fw", 64'(filter_weights), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // W before AW
    axi_write(6'h10, 32'h5, 4'hF, 2'b00, "w_before_aw", 2);
    axi_read(6'h10, 32'h5, 2'b00, "coef0_rd");
    check("fw_no_start", 64'(filter_weights), 64'd0);

    // Full single frame
    exp_fw = '0;
    for (int k = 0; k < KT; k++) begin
      exp_fw[k*CW +: CW] = CW'(vals[k]);
      axi_write(6'(6'h10 + 4*k), 32'(vals[k]), 4'hF, 2'b00, "coef_wr", 0);
    end
    start_cnt = 0;
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl_en", 0);
    wait_run(1'b1, "frame_run");
    repeat (2) @(negedge clk);
    check("frame_starts", 64'(start_cnt), 64'd1);
    check("frame_fw", 64'(filter_weights), 64'(exp_fw));
    pulse_tlast();
    check("frame_done_run", 64'(run), 64'd0);
    axi_read(6'h04, 32'h102, 2'b00, "status_done");
    axi_read(6'h08, 32'h1, 2'b00, "fcnt_one");
    axi_write(6'h00, 32'h0, 4'hF, 2'b00, "ctrl_off", 0);
    axi_read(6'h04, 32'h100, 2'b00, "status_idle");

    // W1C done, state bits read-only, any FRAME_CNT write clears
    axi_write(6'h04, 32'h103, 4'hF, 2'b00, "status_w1c", 0);
    axi_read(6'h04, 32'h0, 2'b00, "status_clr");
    axi_write(6'h08, 32'hFFFF, 4'h0, 2'b00, "fcnt_clr", 0);
    axi_read(6'h08, 32'h0, 2'b00, "fcnt_zero");

    // Continuous mode with a mid-frame coefficient change
    start_cnt = 0;
    axi_write(6'h00, 32'h3, 4'hF, 2'b00, "ctrl_cont", 0);
    wait_run(1'b1, "cont_run");
    run_armed = 1'b1;
    axi_write(6'h20, 32'h6, 4'hF, 2'b00, "coef4_mid", 0);
    check("fw_held_midframe", 64'(filter_weights), 64'(exp_fw));
    pulse_tlast();
    exp_fw2 = exp_fw;
    exp_fw2[4*CW +: CW] = CW'(6);
    check("fw_reloaded", 64'(filter_weights), 64'(exp_fw2));
    pulse_tlast();
    pulse_tlast();
    check("cont_starts", 64'(start_cnt), 64'd4);
    check("cont_run_kept", 64'(run_dropped), 64'd0);
    axi_read(6'h08, 32'h3, 2'b00, "fcnt_three");
    axi_read(6'h20, 32'h6, 2'b00, "coef4_rd");

    // Abort coinciding with tlast
    axi_write(6'h04, 32'h100, 4'hF, 2'b00, "done_clr", 0);
    run_armed = 1'b0;
    write_with_tlast(6'h00, 32'h4, 4'h1, 2'b00, "abort_race");
    check("abort_run", 64'(run), 64'd0);
    axi_read(6'h04, 32'h0, 2'b00, "abort_status");
    axi_read(6'h08, 32'h3, 2'b00, "abort_fcnt");
    axi_read(6'h00, 32'h0, 2'b00, "ctrl_rd");

    // Error responses and strobes
    axi_read(6'h3C, 32'h0, 2'b10, "rd_bad_3c");
    axi_read(6'h34, 32'h0, 2'b10, "rd_bad_34");
    axi_read(6'h30, 32'h1, 2'b00, "rd_coef8");
    axi_write(6'h0C, 32'h1, 4'hF, 2'b10, "wr_reserved", 0);
    axi_read(6'h0C, 32'h0, 2'b00, "rd_reserved");
    axi_write(6'h3C, 32'h1, 4'hF, 2'b10, "wr_bad_3c", 0);
    axi_write(6'h14, 32'h7, 4'h0, 2'b00, "wr_strb0", 0);
    axi_read(6'h14, 32'h2, 2'b00, "coef1_kept");
    axi_write(6'h18, 32'h7, 4'h2, 2'b00, "wr_strb_hi", 0);
    axi_read(6'h18, 32'h3, 2'b00, "coef2_kept");

    // FRAME_CNT clear coinciding with an increment
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl_en2", 0);
    wait_run(1'b1, "run2");
    write_with_tlast(6'h08, 32'h0, 4'hF, 2'b00, "fcnt_race");
    axi_read(6'h08, 32'h1, 2'b00, "fcnt_race_rd");
    axi_read(6'h04, 32'h102, 2'b00, "status_race");

    // Asynchronous reset mid-frame with a pending B
    axi_write(6'h00, 32'h0, 4'hF, 2'b00, "ctrl_off2", 0);
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl_en3", 0);
    wait_run(1'b1, "run3");
    bready = 1'b0;
    @(negedge clk);
    awaddr = 6'h10; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    check("pend_ready", 64'(awready & wready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("pend_bvalid", 64'(bvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_run", 64'(run), 64'd0);
    check("arst_bvalid", 64'(bvalid), 64'd0);
    check("arst_fw", 64'(filter_weights), 64'd0);
`ifdef CONV_CTRL_IRQ_EN
    check("arst_irq", 64'(irq), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(6'h08, 32'h0, 2'b00, "post_rst_fcnt");
    axi_read(6'h10, 32'h0, 2'b00, "post_rst_coef0");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
